// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control path.
// Holds FSM state codes, ALUOp values, opcode/funct values and mux select codes.
// The single-cycle decoder uses the same ALUOp constants.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12
  } state_e;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_XOR = 4'd8;
  localparam logic [3:0] ALU_BEQ = 4'd10;
  localparam logic [3:0] ALU_BNE = 4'd11;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_SLL = 4'd13;
  localparam logic [3:0] ALU_SRL = 4'd14;
  localparam logic [3:0] ALU_NOP = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REGA   = 2'd3;

  localparam logic [1:0] ALUB_B       = 2'd0;
  localparam logic [1:0] ALUB_FOUR    = 2'd1;
  localparam logic [1:0] ALUB_IMM     = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

  // States in which the FSM is stalled on the memory handshake.
  function automatic logic is_mem_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_alu_op_decode.sv
// Purpose: opcode/funct -> ALUOp plus a legal-instruction flag.
// Latency: purely combinational.
// Backpressure: none; no handshake.
module mc_alu_op_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       legal
);

  // Map the instruction to its ALU operation; anything unlisted is illegal.
  always_comb begin
    alu_op = ALU_NOP;
    legal  = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:           alu_op = ALU_ADD;
          FN_SUB:           alu_op = ALU_SUB;
          FN_AND:           alu_op = ALU_AND;
          FN_OR:            alu_op = ALU_OR;
          FN_XOR:           alu_op = ALU_XOR;
          FN_NOR:           alu_op = ALU_NOR;
          FN_SLT:           alu_op = ALU_SLT;
          FN_SLL:           alu_op = ALU_SLL;
          FN_SRL:           alu_op = ALU_SRL;
          FN_JR, FN_JALR:   alu_op = ALU_NOP;
          default:          legal  = 1'b0;
        endcase
      end
      OP_LW, OP_LH, OP_SW, OP_SH: alu_op = ALU_ADD;
      OP_BEQ:                     alu_op = ALU_BEQ;
      OP_BNE:                     alu_op = ALU_BNE;
      OP_ADDI:                    alu_op = ALU_ADD;
      OP_ANDI:                    alu_op = ALU_AND;
      OP_SLTI:                    alu_op = ALU_SLT;
      OP_J, OP_JAL:               alu_op = ALU_NOP;
      default:                    legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Purpose: multi-cycle MIPS control FSM driving the shared ALU/memory datapath.
// Latency: 3-5 cycles per instruction plus one per memory wait cycle.
// Backpressure: stalls on mem_ready in FETCH/MEM_RD/MEM_WR; watchdog aborts with bus_err.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       half,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       jal,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_err
);

  // Counter only needs to reach MEM_TIMEOUT-1; a zero timeout disables the watchdog.
  localparam int              CNT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam bit              WDOG_EN  = (MEM_TIMEOUT != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [3:0]       dec_alu_op;
  logic             dec_legal;
  logic             mem_wait_st;
  logic             timeout;

  mc_alu_op_decode u_alu_op_decode (
    .opcode (opcode),
    .funct  (funct),
    .alu_op (dec_alu_op),
    .legal  (dec_legal)
  );

  assign mem_wait_st = is_mem_wait_state(state_q);
  // Timeout loses to a mem_ready arriving in the same cycle.
  assign timeout     = WDOG_EN && mem_wait_st && !mem_ready && (wait_cnt_q == CNT_LAST);

  // Next state and memory-wait counter.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (!dec_legal) begin
          state_d = S_FETCH;
        end else begin
          case (opcode)
            OP_LW, OP_LH, OP_SW, OP_SH: state_d = S_MEM_ADDR;
            OP_RTYPE:     state_d = ((funct == FN_JR) || (funct == FN_JALR)) ? S_JR : S_R_EXEC;
            OP_BEQ, OP_BNE: state_d = S_BRANCH;
            OP_J, OP_JAL:   state_d = S_JUMP;
            default:        state_d = S_I_EXEC;
          endcase
        end
      end
      S_MEM_ADDR: state_d = ((opcode == OP_LW) || (opcode == OP_LH)) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      default:    state_d = S_FETCH;
    endcase
    if (mem_wait_st && !mem_ready) begin
      if (timeout) begin
        state_d = S_FETCH;
      end else if (WDOG_EN) begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Moore output decode; everything is held at zero while in reset.
  always_comb begin
    pc_en      = 1'b0;
    pc_src     = PC_SRC_ALU;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    half       = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    jal        = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUB_B;
    alu_op     = ALU_NOP;
    instr_done = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    if (!rst) begin
      alu_op = 4'd0;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = ALUB_FOUR;
          alu_op    = ALU_ADD;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
          bus_err   = timeout;
        end
        S_DECODE: begin
          alu_src_b  = ALUB_IMM_SH2;
          alu_op     = ALU_ADD;
          illegal    = !dec_legal;
          instr_done = !dec_legal;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUB_IMM;
          alu_op    = ALU_ADD;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          half     = (opcode == OP_LH);
          bus_err  = timeout;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          half       = (opcode == OP_LH);
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          half       = (opcode == OP_SH);
          instr_done = mem_ready;
          bus_err    = timeout;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = dec_alu_op;
        end
        S_R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUB_IMM;
          alu_op    = dec_alu_op;
        end
        S_I_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_SUB;
          pc_src     = PC_SRC_ALUOUT;
          pc_en      = (opcode == OP_BNE) ? !zero : zero;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_src     = PC_SRC_JUMP;
          pc_en      = 1'b1;
          reg_write  = (opcode == OP_JAL);
          jal        = (opcode == OP_JAL);
          instr_done = 1'b1;
        end
        S_JR: begin
          pc_src     = PC_SRC_REGA;
          pc_en      = 1'b1;
          reg_write  = (funct == FN_JALR);
          jal        = (funct == FN_JALR);
          reg_dst    = (funct == FN_JALR);
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected output traces
// are built from the instruction class, memory wait counts and timeout rule,
// then compared cycle by cycle along with the instruction latency.
module tb_multicycle_controller;

  localparam int TO = 4;

  localparam logic [3:0] A_AND = 4'd0, A_OR = 4'd1, A_ADD = 4'd3, A_SUB = 4'd6,
                         A_SLT = 4'd7, A_XOR = 4'd8, A_NOR = 4'd12, A_SLL = 4'd13,
                         A_SRL = 4'd14, A_NOP = 4'd15;

  localparam int C_BAD = 0, C_R = 1, C_I = 2, C_LD = 3, C_ST = 4, C_BR = 5, C_J = 6, C_JR = 7;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       half;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       jal;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       instr_done;
    logic       illegal;
    logic       bus_err;
  } o_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, mem_read, mem_write, half, ir_write, reg_dst, reg_write;
  logic       mem_to_reg, jal, alu_src_a, instr_done, illegal, bus_err;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_op;

  int total = 0;
  int bad   = 0;

  o_t   exp_q[$];
  logic mr_q[$];
  bit   seq_abort;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .pc_src(pc_src), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .half(half), .ir_write(ir_write),
    .reg_dst(reg_dst), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .jal(jal),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .instr_done(instr_done), .illegal(illegal), .bus_err(bus_err)
  );

  // ---------------- reference model ----------------
  function automatic o_t sample_outs();
    o_t o;
    o.pc_en = pc_en; o.pc_src = pc_src; o.iord = iord; o.mem_read = mem_read;
    o.mem_write = mem_write; o.half = half; o.ir_write = ir_write; o.reg_dst = reg_dst;
    o.reg_write = reg_write; o.mem_to_reg = mem_to_reg; o.jal = jal;
    o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b; o.alu_op = alu_op;
    o.instr_done = instr_done; o.illegal = illegal; o.bus_err = bus_err;
    return o;
  endfunction

  function automatic o_t idle();
    o_t o = '0;
    o.alu_op = A_NOP;
    return o;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: case (fn)
               6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02: return C_R;
               6'h08, 6'h09: return C_JR;
               default: return C_BAD;
             endcase
      6'h02, 6'h03: return C_J;
      6'h04, 6'h05: return C_BR;
      6'h08, 6'h0A, 6'h0C: return C_I;
      6'h23, 6'h21: return C_LD;
      6'h2B, 6'h29: return C_ST;
      default: return C_BAD;
    endcase
  endfunction

  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h20: return A_ADD;  6'h22: return A_SUB;  6'h24: return A_AND;
      6'h25: return A_OR;   6'h26: return A_XOR;  6'h27: return A_NOR;
      6'h2A: return A_SLT;  6'h00: return A_SLL;  6'h02: return A_SRL;
      default: return A_NOP;
    endcase
  endfunction

  function automatic logic [3:0] i_alu(input logic [5:0] op);
    case (op)
      6'h08: return A_ADD;
      6'h0C: return A_AND;
      default: return A_SLT;
    endcase
  endfunction

  // Cycles from start of FETCH to the instr_done cycle, memory waits excluded.
  function automatic int lat_of(input int c);
    case (c)
      C_R, C_I, C_ST: return 4;
      C_LD:           return 5;
      C_BAD:          return 2;
      default:        return 3;
    endcase
  endfunction

  function automatic void push(input o_t e, input logic mr);
    exp_q.push_back(e);
    mr_q.push_back(mr);
  endfunction

  // w stall cycles then completion; w >= TO ends in bus_err on the TO-th stall.
  function automatic bit mem_access(input o_t base, input o_t done, input int w);
    o_t e;
    if (w >= TO) begin
      for (int i = 0; i < TO; i++) begin
        e = base;
        e.bus_err = (i == TO - 1);
        push(e, 1'b0);
      end
      return 1'b1;
    end
    for (int i = 0; i < w; i++) push(base, 1'b0);
    push(done, 1'b1);
    return 1'b0;
  endfunction

  function automatic void build_seq(input logic [5:0] op, input logic [5:0] fn,
                                    input logic z, input int fw, input int mw);
    o_t b, d;
    int c;
    exp_q.delete();
    mr_q.delete();
    seq_abort = 1'b0;
    b = idle(); b.mem_read = 1'b1; b.alu_src_b = 2'd1; b.alu_op = A_ADD;
    d = b; d.ir_write = 1'b1; d.pc_en = 1'b1;
    if (mem_access(b, d, fw)) begin seq_abort = 1'b1; return; end
    c = classify(op, fn);
    b = idle(); b.alu_src_b = 2'd3; b.alu_op = A_ADD;
    if (c == C_BAD) begin
      b.illegal = 1'b1; b.instr_done = 1'b1;
      push(b, rnd());
      return;
    end
    push(b, rnd());
    b = idle();
    case (c)
      C_LD, C_ST: begin
        b.alu_src_a = 1'b1; b.alu_src_b = 2'd2; b.alu_op = A_ADD;
        push(b, rnd());
        b = idle(); b.iord = 1'b1;
        if (c == C_LD) begin
          b.mem_read = 1'b1; b.half = (op == 6'h21);
          if (mem_access(b, b, mw)) begin seq_abort = 1'b1; return; end
          b = idle(); b.reg_write = 1'b1; b.mem_to_reg = 1'b1;
          b.half = (op == 6'h21); b.instr_done = 1'b1;
          push(b, rnd());
        end else begin
          b.mem_write = 1'b1; b.half = (op == 6'h29);
          d = b; d.instr_done = 1'b1;
          if (mem_access(b, d, mw)) seq_abort = 1'b1;
        end
      end
      C_R: begin
        b.alu_src_a = 1'b1; b.alu_src_b = 2'd0; b.alu_op = r_alu(fn);
        push(b, rnd());
        b = idle(); b.reg_write = 1'b1; b.reg_dst = 1'b1; b.instr_done = 1'b1;
        push(b, rnd());
      end
      C_I: begin
        b.alu_src_a = 1'b1; b.alu_src_b = 2'd2; b.alu_op = i_alu(op);
        push(b, rnd());
        b = idle(); b.reg_write = 1'b1; b.instr_done = 1'b1;
        push(b, rnd());
      end
      C_BR: begin
        b.alu_src_a = 1'b1; b.alu_op = A_SUB; b.pc_src = 2'd1;
        b.pc_en = (op == 6'h04) ? z : ~z; b.instr_done = 1'b1;
        push(b, rnd());
      end
      C_J: begin
        b.pc_src = 2'd2; b.pc_en = 1'b1; b.instr_done = 1'b1;
        b.reg_write = (op == 6'h03); b.jal = (op == 6'h03);
        push(b, rnd());
      end
      default: begin
        b.pc_src = 2'd3; b.pc_en = 1'b1; b.instr_done = 1'b1;
        b.reg_write = (fn == 6'h09); b.jal = (fn == 6'h09); b.reg_dst = (fn == 6'h09);
        push(b, rnd());
      end
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic step(input logic rs, input logic mr, output o_t act);
    @(negedge clk);
    rst = rs;
    mem_ready = mr;
    #1;
    act = sample_outs();
  endtask

  // Change the instruction fields only just after an edge so the previous
  // instruction's final transition has already been taken.
  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    @(posedge clk);
    #1;
    opcode = op;
    funct  = fn;
    zero   = z;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    o_t act, zz, e;
    zz = '0;
    rst = 1'b0; mem_ready = 1'b1; opcode = 6'h2B; funct = 6'h00; zero = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, act);
      total++;
      if (act !== zz) begin
        bad++;
        $display("FAIL reset_hold cyc%0d: got %h want %h", i, act, zz);
      end
    end
    step(1'b1, 1'b0, act);
    e = idle(); e.mem_read = 1'b1; e.alu_src_b = 2'd1; e.alu_op = A_ADD;
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL reset_release: got %h want %h", act, e);
    end
  endtask

  localparam int ND = 17;
  logic [5:0] d_op [ND] = '{6'h00, 6'h23, 6'h21, 6'h04, 6'h05, 6'h03, 6'h00, 6'h00, 6'h3F,
                            6'h2B, 6'h29, 6'h00, 6'h00, 6'h0A, 6'h0C, 6'h00, 6'h02};
  logic [5:0] d_fn [ND] = '{6'h20, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h09, 6'h00, 6'h00,
                            6'h00, 6'h00, 6'h20, 6'h3F, 6'h00, 6'h00, 6'h08, 6'h00};
  logic d_z [ND] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  int d_fw [ND] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 4, 0, 0, 0, 0, 0};
  int d_mw [ND] = '{0, 3, 3, 0, 0, 0, 0, 0, 0, 4, 3, 0, 0, 0, 0, 0, 0};
  string d_nm [ND] = '{"add", "lw_wait3", "lh_wait3", "beq_z1", "bne_z1", "jal", "jalr",
                       "zero_word", "illegal_op3f", "sw_timeout", "sh_ready_at_limit",
                       "fetch_timeout", "illegal_fn3f", "slti", "andi", "jr", "j"};

  task automatic test_directed();
    o_t act;
    int lat, want, c;
    for (int n = 0; n < ND; n++) begin
      set_instr(d_op[n], d_fn[n], d_z[n]);
      build_seq(d_op[n], d_fn[n], d_z[n], d_fw[n], d_mw[n]);
      lat = 0;
      for (int k = 0; k < exp_q.size(); k++) begin
        step(1'b1, mr_q[k], act);
        total++;
        if (act !== exp_q[k]) begin
          bad++;
          $display("FAIL %s cyc%0d: got %h want %h", d_nm[n], k, act, exp_q[k]);
        end
        if (act.instr_done === 1'b1 && lat == 0) lat = k + 1;
      end
      c = classify(d_op[n], d_fn[n]);
      want = seq_abort ? 0 : lat_of(c) + d_fw[n] + ((c == C_LD || c == C_ST) ? d_mw[n] : 0);
      total++;
      if (lat !== want) begin
        bad++;
        $display("FAIL %s latency: got %0d want %0d", d_nm[n], lat, want);
      end
    end
  endtask

  logic [5:0] rfn [11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02,
                           6'h08, 6'h09};
  logic [5:0] iop [11] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h23, 6'h21,
                           6'h2B, 6'h29};

  function automatic int pick_wait();
    return ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
  endfunction

  task automatic test_random();
    o_t act;
    logic [5:0] op, fn;
    logic z;
    int fw, mw, lat, want, c, r;
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 24);
      fn = 6'($urandom_range(0, 63));
      if (r < 11) begin
        op = 6'h00;
        fn = rfn[r];
      end else if (r < 22) begin
        op = iop[r - 11];
      end else begin
        op = 6'($urandom_range(0, 63));
      end
      z  = rnd();
      fw = pick_wait();
      mw = pick_wait();
      set_instr(op, fn, z);
      build_seq(op, fn, z, fw, mw);
      lat = 0;
      for (int k = 0; k < exp_q.size(); k++) begin
        step(1'b1, mr_q[k], act);
        total++;
        if (act !== exp_q[k]) begin
          bad++;
          $display("FAIL rand%0d op%h fn%h cyc%0d: got %h want %h", n, op, fn, k, act, exp_q[k]);
        end
        if (act.instr_done === 1'b1 && lat == 0) lat = k + 1;
      end
      c = classify(op, fn);
      want = seq_abort ? 0 : lat_of(c) + fw + ((c == C_LD || c == C_ST) ? mw : 0);
      total++;
      if (lat !== want) begin
        bad++;
        $display("FAIL rand%0d latency op%h fn%h: got %0d want %0d", n, op, fn, lat, want);
      end
    end
  endtask

  task automatic test_reset_mid_store();
    o_t act, zz, e;
    zz = '0;
    set_instr(6'h2B, 6'h00, 1'b0);
    build_seq(6'h2B, 6'h00, 1'b0, 0, TO);
    // FETCH, DECODE, MEM_ADDR and one stalled MEM_WR cycle
    for (int k = 0; k < 4; k++) begin
      step(1'b1, mr_q[k], act);
      total++;
      if (act !== exp_q[k]) begin
        bad++;
        $display("FAIL rst_store_pre cyc%0d: got %h want %h", k, act, exp_q[k]);
      end
    end
    step(1'b0, 1'b1, act);
    total++;
    if (act !== zz) begin
      bad++;
      $display("FAIL rst_store_hold: got %h want %h", act, zz);
    end
    step(1'b1, 1'b0, act);
    e = idle(); e.mem_read = 1'b1; e.alu_src_b = 2'd1; e.alu_op = A_ADD;
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL rst_store_refetch: got %h want %h", act, e);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle MIPS control FSM that sequences the shared datapath (single ALU, unified instruction/data memory, IR, A/B/ALUOut registers) over several clocks per instruction.
- Supports the same instruction set and ALUOp encoding as the single-cycle decoder: lw/sw/lh/sh, beq/bne, addi/andi/slti, j/jal, R-type add/sub/and/or/xor/nor/slt/sll/srl/jr/jalr.
- Adds a variable-latency memory handshake (mem_ready) with a timeout watchdog.

Parameters:
- MEM_TIMEOUT, 16: cycles spent waiting on mem_ready before bus_err fires; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_en  out  1  PC load enable.
- pc_src  out  2  0=ALU result, 1=ALUOut, 2=jump target, 3=register A.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read, mem_write, half  out  1 each  memory strobes; half selects a 16-bit access.
- ir_write  out  1  IR load.
- reg_dst, reg_write, mem_to_reg, jal  out  1 each  register-file write controls; jal writes PC into $31 (or into rd for jalr).
- alu_src_a  out  1  0=PC, 1=A.
- alu_src_b  out  2  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
- alu_op  out  4  AND=0 OR=1 ADD=3 SUB=6 SLT=7 XOR=8 BEQ=10 BNE=11 NOR=12 SLL=13 SRL=14 NOP=15.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode/funct.
- bus_err  out  1  one-cycle pulse on memory timeout.

Behaviour:
- Reset: while rst=0, every output is forced to 0 combinationally, alu_op included (=0). On the next edge state=FETCH and wait_cnt=0. Reset mid-access abandons the access; mem_write never asserts during a reset cycle.
- Outputs are Moore-decoded from the state, plus opcode/funct/zero/mem_ready where noted.
- Defaults in every state: all strobes 0, alu_op=NOP.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD.
  - ir_write = pc_en = mem_ready, pc_src=0.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - ALU computes the branch target: alu_src_a=0, alu_src_b=3, ADD; ALUOut is loaded by the datapath.
  - Next state by opcode: lw/lh/sw/sh -> MEM_ADDR; R-type -> R_EXEC (jr/jalr -> JR); addi/andi/slti -> I_EXEC; beq/bne -> BRANCH; j/jal -> JUMP.
  - Anything else -> FETCH with illegal=1 and instr_done=1.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD. Loads go to MEM_RD; stores go to MEM_WR.
- MEM_RD:
  - Outputs: mem_read=1, iord=1, half=(opcode==lh).
  - Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, half as in MEM_RD; instr_done=1; -> FETCH.
- MEM_WR:
  - Outputs: mem_write=1, iord=1, half=(opcode==sh).
  - On mem_ready: instr_done=1, -> FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_op decoded from funct; -> R_WB.
- R_WB: reg_write=1, reg_dst=1; instr_done; -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=2, alu_op = ADD/AND/SLT for addi/andi/slti; -> I_WB.
- I_WB: reg_write=1, reg_dst=0; instr_done; -> FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1.
  - pc_en = zero for beq, !zero for bne.
  - instr_done; -> FETCH.
- JUMP: pc_src=2, pc_en=1; for jal also reg_write=1, jal=1. instr_done; -> FETCH.
- JR: pc_src=3, pc_en=1; for jalr also reg_write=1, jal=1, reg_dst=1. instr_done; -> FETCH.
- Latency with mem_ready already high: R/I-type 4 cycles, lw/lh 5, sw/sh 4, branch/jump/jr 3. Each wait cycle adds 1.
- Watchdog (memory-wait states FETCH, MEM_RD, MEM_WR):
  - wait_cnt increments each cycle mem_ready=0 and clears on leaving the state.
  - When wait_cnt == MEM_TIMEOUT-1 and mem_ready is still 0: bus_err=1, drop the strobes next cycle, -> FETCH. PC is not advanced; a store is not retired (no instr_done).
  - mem_ready arriving in that same cycle wins: normal completion, no bus_err.
- The all-zero word decodes as sll $0,$0,0 and completes normally; the write to $0 is harmless.

Decomposition:
- Shared package mc_pkg holds: state encoding (4-bit, FETCH=0), ALUOp constants, opcode/funct constants, pc_src/alu_src_b codes. The single-cycle decoder migrates to the same ALUOp constants.
- One sub-module, mc_alu_op_decode: combinational opcode/funct -> alu_op plus a legal flag, shared by DECODE's legality check and the EXEC states.

Test Plan:
- Reset: rst=0 for 2 cycles with mem_ready=1 -> all outputs 0. Release -> FETCH with mem_read=1, iord=0.
- add (opcode 0, funct 0x20), mem_ready=1 -> states FETCH, DECODE, R_EXEC (alu_op=3), R_WB (reg_write=1, reg_dst=1); instr_done on cycle 4.
- lw with mem_ready held low 3 cycles in MEM_RD -> mem_read held for 4 cycles, then MEM_WB with mem_to_reg=1; total 8 cycles. lh variant -> half=1.
- beq with zero=1 -> pc_en=1, pc_src=1 in BRANCH. bne with zero=1 -> pc_en=0. Both complete in 3 cycles.
- jal -> JUMP with pc_en=1, pc_src=2, reg_write=1, jal=1. jalr (funct 0x09) -> JR with pc_src=3, jal=1, reg_dst=1.
- Boundaries:
  - opcode 0x3F -> illegal pulse in DECODE, no strobes, back to FETCH.
  - MEM_TIMEOUT=4, sw with mem_ready=0 -> bus_err on the 4th wait cycle, mem_write drops, no instr_done.
  - rst=0 during MEM_WR -> mem_write=0 in that cycle, FETCH next.
